// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, opcode/funct
// constants, instruction classes and datapath mux/ALU codes.
package mips_mc_pkg;

   typedef enum logic [3:0] {
      StIdle   = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StMemAdr = 4'd3,
      StMemRd  = 4'd4,
      StMemWb  = 4'd5,
      StMemWr  = 4'd6,
      StExec   = 4'd7,
      StRwb    = 4'd8,
      StBranch = 4'd9,
      StJump   = 4'd10,
      StAddiEx = 4'd11,
      StAddiWb = 4'd12,
      StJr     = 4'd13
   } state_e;

   typedef enum logic [2:0] {
      ClsMem  = 3'd0,
      ClsAddi = 3'd1,
      ClsBr   = 3'd2,
      ClsJ    = 3'd3,
      ClsJr   = 3'd4,
      ClsR    = 3'd5,
      ClsIll  = 3'd6
   } op_class_e;

   localparam logic [5:0] OpcRtype = 6'b000000;
   localparam logic [5:0] OpcJ     = 6'b000010;
   localparam logic [5:0] OpcJal   = 6'b000011;
   localparam logic [5:0] OpcBeq   = 6'b000100;
   localparam logic [5:0] OpcBne   = 6'b000101;
   localparam logic [5:0] OpcAddi  = 6'b001000;
   localparam logic [5:0] OpcLw    = 6'b100011;
   localparam logic [5:0] OpcSw    = 6'b101011;
   localparam logic [5:0] FnJr     = 6'b001000;

   localparam logic [1:0] AluAdd   = 2'b00;
   localparam logic [1:0] AluSub   = 2'b01;
   localparam logic [1:0] AluFunct = 2'b10;

   localparam logic [1:0] PcAlu    = 2'b00;
   localparam logic [1:0] PcAluOut = 2'b01;
   localparam logic [1:0] PcJump   = 2'b10;
   localparam logic [1:0] PcRs     = 2'b11;

   localparam logic [1:0] SrcBRt    = 2'b00;
   localparam logic [1:0] SrcBFour  = 2'b01;
   localparam logic [1:0] SrcBImm   = 2'b10;
   localparam logic [1:0] SrcBImmSh = 2'b11;

endpackage

// File: rtl/mips_op_class.sv
// Combinational instruction classifier: opcode/funct -> op_class_e code.
module mips_op_class
   import mips_mc_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] op_class
);

   // Map each supported opcode (and jr funct) onto its execution class
   always_comb begin
      op_class = ClsIll;
      case (opcode)
         OpcLw, OpcSw:   op_class = ClsMem;
         OpcAddi:        op_class = ClsAddi;
         OpcBeq, OpcBne: op_class = ClsBr;
         OpcJ, OpcJal:   op_class = ClsJ;
         OpcRtype:       op_class = (funct == FnJr) ? ClsJr : ClsR;
         default:        op_class = ClsIll;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_fsm.sv
// Multi-cycle MIPS control sequencer: state register, memory wait counter
// with timeout, opcode/funct latches and per-state control strobe decode.
module mips_multicycle_fsm
   import mips_mc_pkg::*;
#(
   parameter int unsigned WAIT_W     = 8,
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       mem_read,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_eq,
   output logic       pc_write_ne,
   output logic [1:0] pc_source,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       link,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state_o
);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [5:0]        opcode_q, funct_q;
   logic [2:0]        op_class;
   logic              mem_state;
   logic              timeout;

   mips_op_class u_op_class (
      .opcode   (opcode),
      .funct    (funct),
      .op_class (op_class)
   );

   assign mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
   // Fires on the WAIT_LIMIT-th consecutive not-ready cycle of a memory state
   assign timeout   = mem_state && !mem_ready && (wait_q == WAIT_W'(WAIT_LIMIT - 1));
   assign state_o   = state_q;

   // State register, wait counter and instruction-field latches
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         wait_q   <= '0;
         opcode_q <= '0;
         funct_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (state_q == StDecode) begin
            opcode_q <= opcode;
            funct_q  <= funct;
         end
      end
   end

   // Next-state and control strobe decode; everything defaults to inactive
   always_comb begin
      state_d     = state_q;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_write_eq = 1'b0;
      pc_write_ne = 1'b0;
      pc_source   = PcAlu;
      alu_src_a   = 1'b0;
      alu_src_b   = SrcBRt;
      alu_op      = AluAdd;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      link        = 1'b0;
      illegal_op  = 1'b0;
      mem_timeout = timeout;

      unique case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            mem_read  = !timeout;
            alu_src_b = SrcBFour;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (timeout)        state_d = StIdle;
            else if (mem_ready) state_d = StDecode;
         end
         StDecode: begin
            // ALU precomputes the branch target while the class is resolved
            alu_src_b = SrcBImmSh;
            case (op_class_e'(op_class))
               ClsMem:  state_d = StMemAdr;
               ClsAddi: state_d = StAddiEx;
               ClsBr:   state_d = StBranch;
               ClsJ:    state_d = StJump;
               ClsJr:   state_d = StJr;
               ClsR:    state_d = StExec;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = StFetch;
               end
            endcase
         end
         StMemAdr: begin
            alu_src_a = 1'b1;
            alu_src_b = SrcBImm;
            state_d   = (opcode_q == OpcSw) ? StMemWr : StMemRd;
         end
         StMemRd: begin
            mem_read = !timeout;
            iord     = 1'b1;
            if (timeout)        state_d = StIdle;
            else if (mem_ready) state_d = StMemWb;
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = StFetch;
         end
         StMemWr: begin
            mem_write = !timeout;
            iord      = 1'b1;
            if (timeout)        state_d = StIdle;
            else if (mem_ready) state_d = StFetch;
         end
         StExec: begin
            alu_src_a = 1'b1;
            alu_op    = AluFunct;
            state_d   = StRwb;
         end
         StRwb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = StFetch;
         end
         StAddiEx: begin
            alu_src_a = 1'b1;
            alu_src_b = SrcBImm;
            state_d   = StAddiWb;
         end
         StAddiWb: begin
            reg_write = 1'b1;
            state_d   = StFetch;
         end
         StBranch: begin
            alu_src_a   = 1'b1;
            alu_op      = AluSub;
            pc_source   = PcAluOut;
            pc_write_eq = (opcode_q == OpcBeq);
            pc_write_ne = (opcode_q == OpcBne);
            state_d     = StFetch;
         end
         StJump: begin
            pc_write  = 1'b1;
            pc_source = PcJump;
            reg_write = (opcode_q == OpcJal);
            link      = (opcode_q == OpcJal);
            state_d   = StFetch;
         end
         StJr: begin
            // Latched funct only ever reaches here as jr; guard keeps it honest
            pc_write  = (funct_q == FnJr);
            pc_source = PcRs;
            state_d   = StFetch;
         end
         default: state_d = StIdle;
      endcase

      // Count only while stalled in the same memory state; any move clears it
      wait_d = (mem_state && !mem_ready && (state_d == state_q)) ? wait_q + WAIT_W'(1) : '0;
   end

endmodule

// File: tb/tb_mips_multicycle_fsm.sv
// Directed bench for mips_multicycle_fsm: walks each instruction class through
// its state sequence and compares state plus the full control vector per cycle.
module tb_mips_multicycle_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funct;
   logic       mem_ready;
   logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_eq, pc_write_ne;
   logic [1:0] pc_source, alu_src_b, alu_op;
   logic       alu_src_a, reg_write, reg_dst, mem_to_reg, link, illegal_op, mem_timeout;
   logic [3:0] state_o;
   logic [19:0] ctl;

   int n_assert = 0;
   int n_fail   = 0;

   // ctl: rd wr iord irw pcw eq ne pcsrc[2] srca srcb[2] aluop[2] rw dst m2r link ill tmo
   localparam logic [19:0] C_IDLE    = 20'b0_0_0_0_0_0_0_00_0_00_00_0_0_0_0_0_0;
   localparam logic [19:0] C_FETCH_R = 20'b1_0_0_1_1_0_0_00_0_01_00_0_0_0_0_0_0;
   localparam logic [19:0] C_FETCH_W = 20'b1_0_0_0_0_0_0_00_0_01_00_0_0_0_0_0_0;
   localparam logic [19:0] C_TMO     = 20'b0_0_0_0_0_0_0_00_0_01_00_0_0_0_0_0_1;
   localparam logic [19:0] C_DECODE  = 20'b0_0_0_0_0_0_0_00_0_11_00_0_0_0_0_0_0;
   localparam logic [19:0] C_DEC_ILL = 20'b0_0_0_0_0_0_0_00_0_11_00_0_0_0_0_1_0;
   localparam logic [19:0] C_MEMADR  = 20'b0_0_0_0_0_0_0_00_1_10_00_0_0_0_0_0_0;
   localparam logic [19:0] C_MEMRD   = 20'b1_0_1_0_0_0_0_00_0_00_00_0_0_0_0_0_0;
   localparam logic [19:0] C_MEMWB   = 20'b0_0_0_0_0_0_0_00_0_00_00_1_0_1_0_0_0;
   localparam logic [19:0] C_MEMWR   = 20'b0_1_1_0_0_0_0_00_0_00_00_0_0_0_0_0_0;
   localparam logic [19:0] C_EXEC    = 20'b0_0_0_0_0_0_0_00_1_00_10_0_0_0_0_0_0;
   localparam logic [19:0] C_RWB     = 20'b0_0_0_0_0_0_0_00_0_00_00_1_1_0_0_0_0;
   localparam logic [19:0] C_ADDIWB  = 20'b0_0_0_0_0_0_0_00_0_00_00_1_0_0_0_0_0;
   localparam logic [19:0] C_BEQ     = 20'b0_0_0_0_0_1_0_01_1_00_01_0_0_0_0_0_0;
   localparam logic [19:0] C_BNE     = 20'b0_0_0_0_0_0_1_01_1_00_01_0_0_0_0_0_0;
   localparam logic [19:0] C_J       = 20'b0_0_0_0_1_0_0_10_0_00_00_0_0_0_0_0_0;
   localparam logic [19:0] C_JAL     = 20'b0_0_0_0_1_0_0_10_0_00_00_1_0_0_1_0_0;
   localparam logic [19:0] C_JR      = 20'b0_0_0_0_1_0_0_11_0_00_00_0_0_0_0_0_0;

   mips_multicycle_fsm #(
      .WAIT_W     (8),
      .WAIT_LIMIT (255)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .opcode      (opcode),
      .funct       (funct),
      .mem_ready   (mem_ready),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .iord        (iord),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .pc_write_eq (pc_write_eq),
      .pc_write_ne (pc_write_ne),
      .pc_source   (pc_source),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_op      (alu_op),
      .reg_write   (reg_write),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .link        (link),
      .illegal_op  (illegal_op),
      .mem_timeout (mem_timeout),
      .state_o     (state_o)
   );

   assign ctl = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_eq, pc_write_ne,
                 pc_source, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
                 link, illegal_op, mem_timeout};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called right after a falling edge with inputs already driven
   task automatic step(input string tag, input logic [3:0] es, input logic [19:0] ec);
      #1;
      check({tag, " state"}, {16'd0, state_o}, {16'd0, es});
      check({tag, " ctl"}, ctl, ec);
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      opcode    = 6'd0;
      funct     = 6'd0;
      mem_ready = 1'b1;
      @(negedge clk);
      step("reset", 4'd0, C_IDLE);
      rst = 1'b0;
      step("release idle", 4'd0, C_IDLE);

      // lw, zero-wait; opcode changed after DECODE must not redirect to MEMWR
      opcode = 6'b100011;
      step("lw fetch", 4'd1, C_FETCH_R);
      step("lw decode", 4'd2, C_DECODE);
      opcode = 6'b101011;
      step("lw memadr", 4'd3, C_MEMADR);
      step("lw memrd", 4'd4, C_MEMRD);
      step("lw memwb", 4'd5, C_MEMWB);

      // sw with three stall cycles in MEMWR
      opcode = 6'b101011;
      step("sw fetch", 4'd1, C_FETCH_R);
      step("sw decode", 4'd2, C_DECODE);
      step("sw memadr", 4'd3, C_MEMADR);
      mem_ready = 1'b0;
      step("sw memwr w1", 4'd6, C_MEMWR);
      step("sw memwr w2", 4'd6, C_MEMWR);
      step("sw memwr w3", 4'd6, C_MEMWR);
      mem_ready = 1'b1;
      step("sw memwr rdy", 4'd6, C_MEMWR);

      // beq then bne
      opcode = 6'b000100;
      step("beq fetch", 4'd1, C_FETCH_R);
      step("beq decode", 4'd2, C_DECODE);
      step("beq branch", 4'd9, C_BEQ);
      opcode = 6'b000101;
      step("bne fetch", 4'd1, C_FETCH_R);
      step("bne decode", 4'd2, C_DECODE);
      step("bne branch", 4'd9, C_BNE);

      // R-type add
      opcode = 6'b000000;
      funct  = 6'b100000;
      step("r fetch", 4'd1, C_FETCH_R);
      step("r decode", 4'd2, C_DECODE);
      step("r exec", 4'd7, C_EXEC);
      step("r rwb", 4'd8, C_RWB);

      // addi
      opcode = 6'b001000;
      step("addi fetch", 4'd1, C_FETCH_R);
      step("addi decode", 4'd2, C_DECODE);
      step("addi ex", 4'd11, C_MEMADR);
      step("addi wb", 4'd12, C_ADDIWB);

      // j, jal
      opcode = 6'b000010;
      step("j fetch", 4'd1, C_FETCH_R);
      step("j decode", 4'd2, C_DECODE);
      step("j jump", 4'd10, C_J);
      opcode = 6'b000011;
      step("jal fetch", 4'd1, C_FETCH_R);
      step("jal decode", 4'd2, C_DECODE);
      step("jal jump", 4'd10, C_JAL);

      // jr
      opcode = 6'b000000;
      funct  = 6'b001000;
      step("jr fetch", 4'd1, C_FETCH_R);
      step("jr decode", 4'd2, C_DECODE);
      step("jr", 4'd13, C_JR);

      // illegal opcode
      opcode = 6'b111111;
      step("ill fetch", 4'd1, C_FETCH_R);
      step("ill decode", 4'd2, C_DEC_ILL);

      // fetch timeout: 254 stalled cycles, pulse on the 255th, IDLE, then FETCH
      mem_ready = 1'b0;
      for (int i = 1; i < 255; i++) step("tmo wait", 4'd1, C_FETCH_W);
      step("tmo pulse", 4'd1, C_TMO);
      mem_ready = 1'b1;
      step("tmo idle", 4'd0, C_IDLE);

      // reset mid-MEMRD
      opcode = 6'b100011;
      step("rst fetch", 4'd1, C_FETCH_R);
      step("rst decode", 4'd2, C_DECODE);
      step("rst memadr", 4'd3, C_MEMADR);
      mem_ready = 1'b0;
      #1;
      check("rst memrd state", {16'd0, state_o}, 20'd4);
      check("rst memrd ctl", ctl, C_MEMRD);
      #2 rst = 1'b1;
      #1;
      check("rst async state", {16'd0, state_o}, 20'd0);
      check("rst async ctl", ctl, C_IDLE);
      @(negedge clk);
      rst = 1'b0;
      step("rst release idle", 4'd0, C_IDLE);
      mem_ready = 1'b1;
      step("rst refetch", 4'd1, C_FETCH_R);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
